// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB initiator types: FSM encoding, default widths, response codes
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_t;

   localparam int DEF_ADDR_W  = 7;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_TIMEOUT = 16;

   localparam logic RSP_OK  = 1'b0;
   localparam logic RSP_ERR = 1'b1;

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - ACCESS wait-state counter with limit compare
// Only instantiated when APB_TIMEOUT_EN is defined.
module apb_wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic PCLK,
   input  logic PRESETn,
   input  logic clear,
   input  logic tick,
   output logic expire
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (tick) begin
         count <= count + 1'b1;
      end
   end

   // Fires on the wait cycle that brings the count up to TIMEOUT.
   assign expire = tick & (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - APB initiator: valid/ready requests to APB SETUP/ACCESS transfers
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT PREADY-low cycles.
module apb_master_if
   import apb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
`ifdef APB_TIMEOUT_EN
   ,
   parameter int TIMEOUT = DEF_TIMEOUT
`endif
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              PSELx,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY
);

   apb_state_t state;
   apb_state_t state_nxt;
   logic       accept;
   logic       complete;
   logic       abort;

   assign req_ready = PRESETn & ((state == ST_IDLE) | ((state == ST_ACCESS) & PREADY));
   assign accept    = req_valid & req_ready;
   assign complete  = (state == ST_ACCESS) & PREADY;
   assign PSELx     = (state != ST_IDLE);
   assign PENABLE   = (state == ST_ACCESS);

`ifdef APB_TIMEOUT_EN
   apb_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .clear   (state == ST_SETUP),
      .tick    ((state == ST_ACCESS) & ~PREADY),
      .expire  (abort)
   );

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         rsp_err <= RSP_OK;
      end else begin
         rsp_err <= abort ? RSP_ERR : RSP_OK;
      end
   end
`else
   assign abort   = 1'b0;
   assign rsp_err = RSP_OK;
`endif

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_nxt = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (PREADY) begin
               state_nxt = accept ? ST_SETUP : ST_IDLE;
            end else if (abort) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Bus fields only move on accept so the APB lines stay quiet between transfers.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         PWRITE <= 1'b0;
         PADDR  <= '0;
         PWDATA <= '0;
      end else if (accept) begin
         PWRITE <= req_write;
         PADDR  <= req_addr;
         PWDATA <= req_wdata;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_valid <= complete | abort;
         if (complete) begin
            rsp_rdata <= PWRITE ? '0 : PRDATA;
         end else if (abort) begin
            rsp_rdata <= '0;
         end
      end
   end

endmodule
